// File: rtl/bram_sdp_split_nch.sv
// N-channel simple-dual-port RAM with per-lane write enables, selectable read-during-write
// behaviour, optional output register and a hardware clear sweep shared by all channels.
module bram_sdp_split_nch #(
  parameter int NCH            = 2,
  parameter int AWIDTH         = 10,
  parameter int DWIDTH         = 18,
  parameter int BE_WIDTH       = 9,
  parameter int READ_MODE      = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr_req,
  output logic                                  busy,
  input  logic [NCH-1:0]                        rce,
  input  logic [NCH*AWIDTH-1:0]                 ra,
  output logic [NCH*DWIDTH-1:0]                 rq,
  output logic [NCH-1:0]                        rvalid,
  input  logic [NCH-1:0]                        wce,
  input  logic [NCH*(DWIDTH/BE_WIDTH)-1:0]      wbe,
  input  logic [NCH*AWIDTH-1:0]                 wa,
  input  logic [NCH*DWIDTH-1:0]                 wd
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam int NBE   = DWIDTH / BE_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          // cnt wraps back to zero on the exit cycle, so no separate reload is needed
          cnt <= cnt + 1'b1;
          if (cnt == AWIDTH'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CLEAR);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] ra_c, wa_c;
    logic [DWIDTH-1:0] wd_c, wmask;
    logic [NBE-1:0]    wbe_c;
    logic              we_c, re_c;
    logic [DWIDTH-1:0] raw, byp_d, byp_m, q1;
    logic              byp, v1;

    assign ra_c  = ra[c*AWIDTH +: AWIDTH];
    assign wa_c  = wa[c*AWIDTH +: AWIDTH];
    assign wd_c  = wd[c*DWIDTH +: DWIDTH];
    assign wbe_c = wbe[c*NBE +: NBE];
    assign we_c  = wce[c] & ~busy;
    assign re_c  = rce[c] & ~busy;

    always_comb begin
      wmask = '0;
      for (int b = 0; b < NBE; b++) wmask[b*BE_WIDTH +: BE_WIDTH] = {BE_WIDTH{wbe_c[b]}};
    end

    always_ff @(posedge clk) begin
      if (busy) begin
        mem[cnt] <= '0;
      end else if (we_c) begin
        for (int b = 0; b < NBE; b++)
          if (wbe_c[b]) mem[wa_c][b*BE_WIDTH +: BE_WIDTH] <= wd_c[b*BE_WIDTH +: BE_WIDTH];
      end
    end

    // Array read stays a plain read-first port; write-first is a registered bypass merged after it
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        raw   <= '0;
        byp   <= 1'b0;
        byp_d <= '0;
        byp_m <= '0;
        v1    <= 1'b0;
      end else begin
        v1 <= re_c;
        if (re_c) begin
          raw   <= mem[ra_c];
          byp   <= (READ_MODE != 0) && we_c && (wa_c == ra_c);
          byp_d <= wd_c;
          byp_m <= wmask;
        end
      end
    end

    assign q1 = byp ? ((byp_d & byp_m) | (raw & ~byp_m)) : raw;

    if (OUT_REG != 0) begin : g_oreg
      logic [DWIDTH-1:0] q2;
      logic              v2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q2 <= '0;
          v2 <= 1'b0;
        end else begin
          q2 <= q1;
          v2 <= v1;
        end
      end

      assign rq[c*DWIDTH +: DWIDTH] = q2;
      assign rvalid[c]              = v2;
    end else begin : g_direct
      assign rq[c*DWIDTH +: DWIDTH] = q1;
      assign rvalid[c]              = v1;
    end
  end

endmodule

// File: tb/tb_bram_sdp_split_nch.sv
// Scoreboard bench: two instances (read-first/no out reg, write-first/out reg) share stimulus
// and are checked against an array-level model of memory contents and clear timing.
module tb_bram_sdp_split_nch;
  localparam int NCH   = 2;
  localparam int AW    = 10;
  localparam int DW    = 18;
  localparam int BEW   = 9;
  localparam int NBE   = DW / BEW;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_req = 1'b0;
  logic [NCH-1:0]     rce = '0, wce = '0;
  logic [NCH*AW-1:0]  ra = '0, wa = '0;
  logic [NCH*NBE-1:0] wbe = '0;
  logic [NCH*DW-1:0]  wd = '0;
  logic               busy_a, busy_b;
  logic [NCH*DW-1:0]  rq_a, rq_b;
  logic [NCH-1:0]     rv_a, rv_b;

  bram_sdp_split_nch #(.NCH(NCH), .AWIDTH(AW), .DWIDTH(DW), .BE_WIDTH(BEW),
                       .READ_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
    .rce(rce), .ra(ra), .rq(rq_a), .rvalid(rv_a),
    .wce(wce), .wbe(wbe), .wa(wa), .wd(wd));

  bram_sdp_split_nch #(.NCH(NCH), .AWIDTH(AW), .DWIDTH(DW), .BE_WIDTH(BEW),
                       .READ_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
    .rce(rce), .ra(ra), .rq(rq_b), .rvalid(rv_b),
    .wce(wce), .wbe(wbe), .wa(wa), .wd(wd));

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          sbq [2*NCH][$];
  logic [DW-1:0] mem_m [NCH][DEPTH];
  int cyc = 0;
  int rem = DEPTH;
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic zero_model();
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < DEPTH; a++) mem_m[c][a] = '0;
  endtask

  task automatic flush_sb();
    for (int k = 0; k < 2*NCH; k++) sbq[k].delete();
  endtask

  // Reference: a busy countdown plus whole-array clear; reads see the array before (dut_a)
  // or after (dut_b) the same-edge writes.
  always @(posedge clk) begin
    logic [AW-1:0] ra_c, wa_c;
    logic [DW-1:0] old;
    exp_t e;
    cyc++;
    if (rst) begin
      rem = DEPTH;
      zero_model();
      flush_sb();
    end else if (rem > 0) begin
      rem--;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        ra_c = ra[c*AW +: AW];
        wa_c = wa[c*AW +: AW];
        old  = mem_m[c][ra_c];
        if (wce[c])
          for (int b = 0; b < NBE; b++)
            if (wbe[c*NBE + b]) mem_m[c][wa_c][b*BEW +: BEW] = wd[c*DW + b*BEW +: BEW];
        if (rce[c]) begin
          e.due = cyc;     e.d = old;              sbq[c].push_back(e);
          e.due = cyc + 1; e.d = mem_m[c][ra_c];   sbq[NCH + c].push_back(e);
        end
      end
      if (clr_req) begin
        rem = DEPTH;
        zero_model();
      end
    end
  end

  always @(negedge clk) begin
    logic          rv, exp_v;
    logic [DW-1:0] q;
    exp_t e;
    int k;
    if (rst) begin
      chk("rst_busy_a", 32'(busy_a), 32'd1);
      chk("rst_busy_b", 32'(busy_b), 32'd1);
      chk("rst_rvalid_a", 32'(rv_a), 32'd0);
      chk("rst_rvalid_b", 32'(rv_b), 32'd0);
      chk("rst_rq_a_ch0", 32'(rq_a[DW-1:0]), 32'd0);
      chk("rst_rq_b_ch1", 32'(rq_b[2*DW-1:DW]), 32'd0);
    end else begin
      chk("busy_a", 32'(busy_a), 32'(rem > 0));
      chk("busy_b", 32'(busy_b), 32'(rem > 0));
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NCH; c++) begin
          k  = d*NCH + c;
          rv = (d == 1) ? rv_b[c] : rv_a[c];
          q  = (d == 1) ? rq_b[c*DW +: DW] : rq_a[c*DW +: DW];
          exp_v = (sbq[k].size() > 0) && (sbq[k][0].due == cyc);
          chk($sformatf("rvalid_%s_ch%0d", (d == 1) ? "b" : "a", c), 32'(rv), 32'(exp_v));
          if (exp_v) begin
            e = sbq[k].pop_front();
            chk($sformatf("rq_%s_ch%0d", (d == 1) ? "b" : "a", c), 32'(q), 32'(e.d));
          end
        end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    rce = '0;
    wce = '0;
    clr_req = 1'b0;
  endtask

  task automatic wr(input int c, input int a, input logic [DW-1:0] d, input logic [NBE-1:0] be);
    wce[c] = 1'b1;
    wa[c*AW +: AW] = AW'(a);
    wd[c*DW +: DW] = d;
    wbe[c*NBE +: NBE] = be;
  endtask

  task automatic rd(input int c, input int a);
    rce[c] = 1'b1;
    ra[c*AW +: AW] = AW'(a);
  endtask

  task automatic noise(input int amax);
    rce = NCH'($urandom);
    wce = NCH'($urandom);
    wbe = (NCH*NBE)'($urandom);
    for (int c = 0; c < NCH; c++) begin
      ra[c*AW +: AW] = AW'($urandom_range(0, amax));
      wa[c*AW +: AW] = AW'($urandom_range(0, amax));
      wd[c*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    flush_sb();
    rem = DEPTH;
    idle();
    tick(n);
    rst = 1'b0;
  endtask

  task automatic wait_sweep();
    for (int i = 0; i < 2*DEPTH && rem > 0; i++) tick(1);
  endtask

  initial begin
    #1;
    do_reset(3);
    repeat (DEPTH - 1) begin noise(DEPTH - 1); tick(1); end
    idle(); tick(1);
    rd(0, 'h3FF); tick(1); idle(); tick(2);

    wr(1, 'h005, 18'h3FFFF, 2'b11); tick(1);
    wr(1, 'h005, 18'h00000, 2'b01); tick(1);
    idle(); rd(1, 'h005); tick(1); idle(); tick(2);

    wr(0, 'h010, 18'h00AAA, 2'b11); tick(1);
    wr(0, 'h010, 18'h15555, 2'b11); rd(0, 'h010); tick(1); idle(); tick(2);
    wr(0, 'h010, 18'h3FFFF, 2'b00); rd(0, 'h010); tick(1); idle(); tick(2);

    wr(0, 'h001, 18'h00111, 2'b11); wr(1, 'h002, 18'h00222, 2'b11); tick(1); idle();
    rd(0, 'h001); tick(1); rd(0, 'h002); tick(1); rd(0, 'h003); tick(1); idle(); tick(4);

    wr(0, 'h020, 18'h12345, 2'b11); clr_req = 1'b1; tick(1); idle();
    repeat (300) begin noise(63); tick(1); end
    idle(); clr_req = 1'b1; tick(1); idle();
    wait_sweep(); tick(1);
    rd(0, 'h020); tick(1); idle(); tick(2);

    clr_req = 1'b1; tick(1); idle();
    tick(512);
    do_reset(2);
    repeat (DEPTH - 1) begin noise(31); tick(1); end
    idle(); tick(2);

    wr(0, 'h007, 18'h11111, 2'b11); wr(1, 'h007, 18'h22222, 2'b11); tick(1); idle();
    rd(0, 'h007); rd(1, 'h007); tick(1); idle(); tick(2);

    repeat (3000) begin noise(15); tick(1); end
    idle(); tick(4);

    for (int k = 0; k < 2*NCH; k++) chk($sformatf("drain_q%0d", k), 32'(sbq[k].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
